ffd_arbiter: RTL and testbench
==============================

# ffd_arbiter

Round-robin arbiter and sequencer for a shared WIDTH-bit D-register built from falling-edge flip-flops. Up to four requesters compete for the register. The block grants one owner at a time for at most HOLD cycles and loads that owner's data word into the register at grant. The register value `q` and its complement `nq` are exported to the downstream datapath.

## Interface
Parameters:
- `WIDTH`, default 8: width of the shared register and of each requester data slice.
- `HOLD`, default 2: maximum grant length in cycles; legal range 1..16.

Ports:
- `clk`  in  1: single clock. All state updates on the falling edge.
- `rst`  in  1: reset, asynchronous and active-low. `rst`=0 forces the reset state immediately.
- `req`  in  4: request lines; `req[i]` is held high while requester i wants the register.
- `din`  in  4*WIDTH: data slices; requester i drives `din[i*WIDTH +: WIDTH]`.
- `clr`  in  1: synchronous clear of `q`, sampled on the falling edge.
- `gnt`  out  4: one-hot grant, registered.
- `owner`  out  2: index of the current or most recent grantee, registered.
- `busy`  out  1: high while in GRANT.
- `q`  out  WIDTH: shared register contents.
- `nq`  out  WIDTH: bitwise complement of `q`, combinational.

## Operation
- Internal state: FSM {IDLE, GRANT}, round-robin pointer `ptr`[1:0], hold counter `cnt`[3:0].
- Reset values (while `rst`=0):
  - FSM=IDLE, `ptr`=3, `cnt`=0.
  - `gnt`=0, `owner`=0, `busy`=0, `q`=0, `nq`=all ones.
- Winner search order: `ptr`+1, `ptr`+2, `ptr`+3, `ptr` (mod 4). The first asserted `req` wins. After reset, requester 0 has top priority.
- IDLE, on edge with `req`≠0:
  - `gnt`<=onehot(winner), `owner`<=winner, `q`<=slice(winner), `cnt`<=HOLD-1, `busy`<=1.
  - FSM->GRANT.
- IDLE, on edge with `req`=0: no change.
- GRANT, on edge with `req[owner]`=0 or `cnt`=0:
  - `gnt`<=0, `busy`<=0, `ptr`<=`owner`.
  - FSM->IDLE.
- GRANT, otherwise: `cnt`<=`cnt`-1. `gnt`, `owner` and `q` hold.
- `q` loads only at grant. Changes on `din` during GRANT are ignored.
- `clr`=1 on an edge: `q`<=0, taking priority over a simultaneous grant load. The FSM, `gnt`, `owner` and `ptr` still advance normally. `clr` in IDLE with no grant clears `q` only.
- Requests from non-owners during GRANT are ignored. They are arbitrated at the next IDLE edge.
- `owner` keeps its last value in IDLE.

## Timing
- Grant latency: `req` sampled at falling edge n gives `gnt` visible after edge n. No grant occurs while `rst`=0.
- Grant length: exactly HOLD cycles when the owner keeps `req` high. HOLD=1 gives a one-cycle grant.
- Early release: the owner drops `req` before edge m in GRANT, and `gnt`=0 after edge m.
- At least one IDLE cycle (`gnt`=0) separates consecutive grants, including a re-grant to the same requester. This is the fairness gap.
- With all four requesting continuously, each grant period is HOLD+1 cycles. Owners rotate 0,1,2,3,0,...
- Reset assertion mid-GRANT clears all state asynchronously. `gnt` drops without waiting for an edge.
- Reset release: the first falling edge after `rst` goes high is a normal IDLE evaluation.
- `nq` follows `q` combinationally with no extra cycle.

## Test plan
- Reset: assert `rst`=0 mid-GRANT, between edges.
  - Required: immediately `gnt`=0000, `busy`=0, `q`=0x00, `nq`=0xFF.
  - After release and `req`=1111: first `gnt`=0001.
- Single requester, HOLD=2: `req`=0001, `din[7:0]`=0xA5.
  - Required: `gnt`=0001 for 2 cycles, `q`=0xA5, `nq`=0x5A.
  - Then 1 cycle `gnt`=0000, then `gnt`=0001 again.
- Full contention, HOLD=2: `req`=1111, distinct slices 0x11/0x22/0x33/0x44.
  - Required: `owner` sequence 0,1,2,3,0, each `gnt` 2 cycles plus 1 idle cycle.
  - `q` follows 0x11,0x22,0x33,0x44.
- Early release, HOLD=4: requester 2 granted, drops `req` after 1 cycle.
  - Required: `gnt`=0000 on the next edge, `ptr`=2, and requester 3 is served next if requesting.
- `clr`:
  - `clr`=1 on the grant edge: `q`=0x00 while `gnt` still asserts.
  - `clr`=1 mid-GRANT: `q`=0x00 next edge, `gnt` unchanged.
- Data stability: change the owner's `din` slice during GRANT -> `q` unchanged until the next grant.

Source files
------------

// File: rtl/ffd_arbiter.sv
// ffd_arbiter
//   Round-robin arbiter and sequencer for a shared WIDTH-bit D-register made of
//   falling-edge flip-flops. Up to four requesters compete. Each grant lasts at
//   most HOLD cycles. The winner's data slice is loaded into the register on the
//   grant edge.
//
// Ports
//   clk    : clock; all state changes on the falling edge
//   rst    : async active-low reset
//   req    : [3:0] request lines, held high while a requester wants the register
//   din    : [4*WIDTH-1:0] data slices, requester i drives din[i*WIDTH +: WIDTH]
//   clr    : sync clear of q; overrides a simultaneous grant load
//   gnt    : [3:0] one-hot grant (registered)
//   owner  : [1:0] current or most recent grantee (registered)
//   busy   : high while in GRANT
//   q      : shared register contents
//   nq     : ~q (combinational)

// One bit of the shared register: falling-edge D flip-flop with load enable.
module ffd_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(negedge clk or negedge rst) begin
    if (!rst)    q <= 1'b0;
    else if (en) q <= d;
  end
endmodule

module ffd_arbiter #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2   // 1..16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   din,
  input  logic                 clr,
  output logic [3:0]           gnt,
  output logic [1:0]           owner,
  output logic                 busy,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     nq
);

  localparam logic [3:0] CNT_INIT = 4'(HOLD - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;

  // Unpack the data bus into per-requester slices.
  logic [WIDTH-1:0] slice [4];
  for (genvar i = 0; i < 4; i++) begin : g_slice
    assign slice[i] = din[i*WIDTH +: WIDTH];
  end

  // Winner search: ptr+1, ptr+2, ptr+3, ptr. ptr resets to 3 so requester 0
  // leads after reset; afterwards the last owner drops to lowest priority.
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Release when the owner lets go or the hold budget is spent.
  logic release_now;
  assign release_now = !req[owner] || (cnt == 4'd0);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= 2'd3;
      cnt   <= 4'd0;
      gnt   <= 4'b0000;
      owner <= 2'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= 4'b0001 << win;
            owner <= win;
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          // Always returning through IDLE gives the one-cycle fairness gap,
          // even when the same requester would win again.
          if (release_now) begin
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            ptr   <= owner;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register loads only on the grant edge; clr wins over that load.
  logic             load;
  logic             q_en;
  logic [WIDTH-1:0] q_d;
  assign load = (state == IDLE) && found;
  assign q_en = load | clr;
  assign q_d  = clr ? '0 : slice[win];

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    ffd_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (q_en),
      .d   (q_d[b]),
      .q   (q[b])
    );
  end

  assign nq = ~q;

endmodule

// File: tb/tb_ffd_arbiter.sv
module tb_ffd_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  req4 = 4'b0000;
  logic [31:0] din = '0;
  logic        clr = 1'b0;

  logic [3:0]  gnt, gnt4;
  logic [1:0]  owner, owner4;
  logic        busy, busy4;
  logic [7:0]  q, nq, q4, nq4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ffd_arbiter #(.WIDTH(8), .HOLD(2)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .clr(clr),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q), .nq(nq)
  );

  ffd_arbiter #(.WIDTH(8), .HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .din(din), .clr(clr),
    .gnt(gnt4), .owner(owner4), .busy(busy4), .q(q4), .nq(nq4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance across one falling edge and settle before sampling.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_gnt",   32'(gnt),   32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_q",     32'(q),     32'h00);
    chk("rst_nq",    32'(nq),    32'hFF);
    @(posedge clk); #2;
    rst = 1'b1;

    // Single requester, HOLD=2
    din[7:0] = 8'hA5;
    req = 4'b0001;
    step();
    chk("single_gnt1", 32'(gnt),  32'h1);
    chk("single_q",    32'(q),    32'hA5);
    chk("single_nq",   32'(nq),   32'h5A);
    chk("single_busy", 32'(busy), 32'h1);
    step();
    chk("single_gnt2", 32'(gnt),  32'h1);
    step();
    chk("single_gap",  32'(gnt),  32'h0);
    chk("single_gapb", 32'(busy), 32'h0);
    step();
    chk("single_regnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    chk("single_rel", 32'(gnt), 32'h0);
    chk("single_qkeep", 32'(q), 32'hA5);

    // Reset mid-GRANT, between edges (ptr=0, so requester 1 wins)
    req = 4'b0010;
    step();
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt",  32'(gnt),  32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_q",    32'(q),    32'h00);
    chk("mid_rst_nq",   32'(nq),   32'hFF);
    @(negedge clk); #2;
    chk("in_rst_gnt", 32'(gnt), 32'h0);
    rst = 1'b1;

    // Full contention: owners 0,1,2,3,0, HOLD cycles each plus one idle
    din = 32'h44332211;
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("cont_gnt_a%0d", k), 32'(gnt),   32'(4'b0001 << (k % 4)));
      chk($sformatf("cont_own%0d", k),   32'(owner), 32'(k % 4));
      chk($sformatf("cont_q%0d", k),     32'(q),     32'(8'h11 * ((k % 4) + 1)));
      step();
      chk($sformatf("cont_gnt_b%0d", k), 32'(gnt),   32'(4'b0001 << (k % 4)));
      if (k == 4) req = 4'b0000;
      step();
      chk($sformatf("cont_idle%0d", k),  32'(gnt),   32'h0);
      if (k < 4) step();
    end

    // clr on the grant edge, then clr mid-GRANT (ptr=0, requester 1 wins)
    req = 4'b0010;
    clr = 1'b1;
    step();
    chk("clr_gedge_gnt", 32'(gnt), 32'h2);
    chk("clr_gedge_q",   32'(q),   32'h00);
    clr = 1'b0;
    step();
    chk("clr_hold_gnt", 32'(gnt), 32'h2);
    chk("clr_hold_q",   32'(q),   32'h00);
    step();
    chk("clr_gap", 32'(gnt), 32'h0);
    step();
    chk("clr_regnt_q", 32'(q), 32'h22);
    clr = 1'b1;
    step();
    chk("clr_mid_q",   32'(q),   32'h00);
    chk("clr_mid_gnt", 32'(gnt), 32'h2);
    clr = 1'b0;
    req = 4'b0000;
    step();
    chk("clr_rel", 32'(gnt), 32'h0);

    // Data stability (ptr=1, requester 2)
    req = 4'b0100;
    step();
    chk("stab_gnt", 32'(gnt), 32'h4);
    chk("stab_q0",  32'(q),   32'h33);
    din[23:16] = 8'h99;
    step();
    chk("stab_q1",  32'(q),   32'h33);
    step();
    chk("stab_gap_q", 32'(q), 32'h33);
    step();
    chk("stab_newq", 32'(q),  32'h99);
    req = 4'b0000;
    step();

    // HOLD=4: early release by requester 2, then requester 3 next
    req4 = 4'b0100;
    step();
    chk("early_gnt",   32'(gnt4),   32'h4);
    chk("early_owner", 32'(owner4), 32'h2);
    req4 = 4'b1011;
    step();
    chk("early_rel",  32'(gnt4),  32'h0);
    chk("early_busy", 32'(busy4), 32'h0);
    step();
    chk("early_next_gnt",   32'(gnt4),   32'h8);
    chk("early_next_owner", 32'(owner4), 32'h3);
    chk("early_next_q",     32'(q4),     32'h44);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("hold4_gnt%0d", k), 32'(gnt4), 32'h8);
    end
    step();
    chk("hold4_rel", 32'(gnt4), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
